// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  // Access size field of a request
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // State encoding of the memory-port sequencer
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_DATA  = 3'd3;
  localparam logic [2:0] ST_WR_ISSUE = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_SETUP    = ST_SETUP,
    S_RD_ISSUE = ST_RD_ISSUE,
    S_RD_DATA  = ST_RD_DATA,
    S_WR_ISSUE = ST_WR_ISSUE,
    S_RESP     = ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load extract + zero/sign extension, and the merge of
// right-justified store data into the lanes of a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_data
);

  logic [31:0] w_shifted;
  logic [31:0] w_wsrc;
  logic [3:0]  w_lane_we;

  // Bring the addressed lane down to bit 0; aligned halves/words share the shift.
  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // Load result: extend the low byte/half of the shifted word, full word otherwise
  always_comb begin
    o_load_data = w_shifted;
    case (i_size)
      SIZE_BYTE: o_load_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_load_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:   o_load_data = w_shifted;
    endcase
  end

  // Replicate store data across lanes so each lane only has to pick old or new
  assign w_wsrc = (i_size == SIZE_BYTE) ? {4{i_wdata[7:0]}}  :
                  (i_size == SIZE_HALF) ? {2{i_wdata[15:0]}} : i_wdata;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign w_lane_we[gi] = (i_size == SIZE_BYTE) ? (i_offset == LANE) :
                           (i_size == SIZE_HALF) ? (i_offset[1] == LANE[1]) : 1'b1;
    assign o_store_data[gi*8 +: 8] = w_lane_we[gi] ? w_wsrc[gi*8 +: 8] : i_rdata[gi*8 +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, address set up one cycle
// ahead of each single-cycle MemRead/MemWrite pulse, sub-word stores done as
// read-modify-write, response returned over a valid/ready handshake.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ReadAddress,
  output logic [31:0] WriteAddress,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  lsu_state_t  r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_offset;
  logic [31:0] r_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_addr_out;
  logic [31:0] r_wdata_out;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_store_data;

  // Reject reserved size, misaligned half/word and words beyond the memory
  assign w_req_err = (req_size == SIZE_RSVD)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   || ({2'b00, req_addr[31:2]} >= DEPTH_W);

  lsu_lane_align u_align (
    .i_size       (r_size),
    .i_offset     (r_offset),
    .i_signed     (r_signed),
    .i_rdata      (ReadData),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_data (w_store_data)
  );

  // Sequencer: request latch, memory command pulses and response registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_signed     <= 1'b0;
      r_offset     <= 2'b00;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr_out   <= '0;
      r_wdata_out  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      // Command strobes are single-cycle unless a state re-asserts them
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_offset <= req_addr[1:0];
            r_wdata  <= req_wdata;
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= S_RESP;
            end else begin
              // Address goes out now so memory has sampled it before any command
              r_addr_out <= {req_addr[31:2], 2'b00};
              r_state    <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_write && (r_size == SIZE_WORD)) begin
            r_wdata_out <= r_wdata;
            r_mem_write <= 1'b1;
            r_state     <= S_WR_ISSUE;
          end else begin
            r_mem_read <= 1'b1;
            r_state    <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (r_write) begin
            // Sub-word store: write back the old word with the new lane(s)
            r_wdata_out <= w_store_data;
            r_mem_write <= 1'b1;
            r_state     <= S_WR_ISSUE;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_error <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          r_resp_rdata <= '0;
          r_resp_error <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == S_IDLE) && Reset_n;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_error   = r_resp_error;
  assign MemRead      = r_mem_read;
  assign MemWrite     = r_mem_write;
  assign ReadAddress  = r_addr_out;
  assign WriteAddress = r_addr_out;
  assign WriteData    = r_wdata_out;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural Data_Memory (address sampled
// every edge, command acts on the previously sampled address, registered read).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] ReadAddress, WriteAddress, WriteData;
  logic [31:0] ReadData = 32'h0;

  always #5 Clock = ~Clock;

  load_store_unit #(.DEPTH(32)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ReadAddress  (ReadAddress),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .ReadData     (ReadData)
  );

  // Data memory model (not reset)
  logic [31:0] mem [0:31];
  logic [31:0] maddr_q = 32'h0;
  always @(posedge Clock) begin
    maddr_q <= ReadAddress;
    if (MemWrite) mem[maddr_q[6:2]] <= WriteData;
    if (MemRead)  ReadData <= mem[maddr_q[6:2]];
  end

  // Command pulse monitor
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic both_seen = 1'b0;
  always @(negedge Clock) begin
    if (MemRead)  rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (MemRead && MemWrite) both_seen = 1'b1;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  vec_t none;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;
  int   rd0, wr0;

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_rd, input int exp_wr);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    req_write  = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
  endtask

  // Present a request, wait (bounded) for acceptance, push its expectation
  task automatic issue(input vec_t v);
    logic got;
    exp_t e;
    drive(v);
    req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (req_ready) got = 1'b1;
      else @(negedge Clock);
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge Clock);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
    e.rd = v.exp_rd; e.wr = v.exp_wr;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the response, compare against the scoreboard, then
  // optionally hold resp_ready low for a few cycles before the handshake
  task automatic collect(input int hold, input logic has_next, input vec_t nxt);
    int   lat;
    logic seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge Clock);
      lat++;
      if (lat == 1) begin
        if (has_next) begin drive(nxt); req_valid = 1'b1; end
        else req_valid = 1'b0;
      end
      if (resp_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
      sb.delete();
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d: rdata=%h err=%b lat=%0d reads=%0d writes=%0d", n_txn, resp_rdata,
             resp_error, lat, rd_cnt - rd0, wr_cnt - wr0);
    chk("resp_rdata", resp_rdata, e.rdata);
    chk("resp_error", {31'b0, resp_error}, {31'b0, e.err});
    chk("latency", 32'(lat), 32'(e.lat));
    chk("memread_pulses", 32'(rd_cnt - rd0), 32'(e.rd));
    chk("memwrite_pulses", 32'(wr_cnt - wr0), 32'(e.wr));
    for (int h = 0; h < hold; h++) begin
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_resp_rdata", resp_rdata, e.rdata);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge Clock);
    end
    resp_ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    resp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {31'b0, |{MemRead, MemWrite, ReadAddress, WriteAddress, WriteData,
                      resp_valid, resp_rdata, resp_error, req_ready}}, 32'd0);
  endtask

  vec_t v_a, v_b;

  initial begin
    Reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    none = mk(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    drive(none);
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1] = 32'd84;
    mem[2] = 32'd11;

    //            wr    size       sgn   addr    wdata          exp_rdata     err  lat rd wr
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h04, 32'h0,        32'h00000054, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b1, SIZE_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 3, 0, 1));
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b1, SIZE_BYTE, 1'b0, 32'h09, 32'h12345680, 32'h00000000, 1'b0, 5, 1, 1));
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0,        32'hDEAD80EF, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_BYTE, 1'b1, 32'h09, 32'h0,        32'hFFFFFF80, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_BYTE, 1'b0, 32'h09, 32'h0,        32'h00000080, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_HALF, 1'b1, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_HALF, 1'b0, 32'h0A, 32'h0,        32'h0000DEAD, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_HALF, 1'b0, 32'h03, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h80, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
    tbl.push_back(mk(1'b0, SIZE_RSVD, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1, 1, 0, 0));
    tbl.push_back(mk(1'b1, SIZE_WORD, 1'b0, 32'h02, 32'h11111111, 32'h00000000, 1'b1, 1, 0, 0));
    tbl.push_back(mk(1'b1, SIZE_HALF, 1'b0, 32'h0E, 32'hABCD1234, 32'h00000000, 1'b0, 5, 1, 1));
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h0C, 32'h0,        32'h12340000, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_BYTE, 1'b1, 32'h04, 32'h0,        32'h00000054, 1'b0, 4, 1, 0));
    tbl.push_back(mk(1'b0, SIZE_WORD, 1'b0, 32'h7C, 32'h0,        32'h00000000, 1'b0, 4, 1, 0));

    // Reset state
    repeat (3) @(negedge Clock);
    chk_reset_outputs("reset_outputs");
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Table-driven transactions
    foreach (tbl[i]) begin
      issue(tbl[i]);
      collect(0, 1'b0, none);
    end

    // Stalled response with a competing request held on req_valid
    v_a = mk(1'b0, SIZE_WORD, 1'b0, 32'h04, 32'h0, 32'h00000054, 1'b0, 4, 1, 0);
    v_b = mk(1'b0, SIZE_WORD, 1'b0, 32'h08, 32'h0, 32'hDEAD80EF, 1'b0, 4, 1, 0);
    issue(v_a);
    collect(3, 1'b1, v_b);
    chk("ready_after_handshake", {31'b0, req_ready}, 32'd1);
    issue(v_b);
    collect(0, 1'b0, none);

    // Reset during RD_ISSUE aborts the load
    issue(v_a);
    @(negedge Clock);
    req_valid = 1'b0;
    @(negedge Clock);
    chk("rd_issue_memread", {31'b0, MemRead}, 32'd1);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk_reset_outputs("reset_in_rd_issue");
    sb.delete();
    Reset_n = 1'b1;
    @(negedge Clock);
    issue(v_a);
    collect(0, 1'b0, none);

    // Reset during WR_ISSUE of a word store still lands the write
    issue(mk(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h00000005, 32'h0, 1'b0, 3, 0, 1));
    @(negedge Clock);
    req_valid = 1'b0;
    @(negedge Clock);
    chk("wr_issue_memwrite", {31'b0, MemWrite}, 32'd1);
    Reset_n = 1'b0;
    @(negedge Clock);
    chk_reset_outputs("reset_in_wr_issue");
    chk("mem_word4_after_reset", mem[4], 32'h00000005);
    sb.delete();
    Reset_n = 1'b1;
    @(negedge Clock);
    issue(mk(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h00000005, 1'b0, 4, 1, 0));
    collect(0, 1'b0, none);

    chk("read_write_overlap", {31'b0, both_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
